// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for a small ARM-like datapath.
//
// Decodes the latched instruction, sequences a Moore main FSM and holds the
// NZCV flag register. It drives every select and enable of the datapath.
// Architectural writes (register file, memory, PC, flags) are gated by the
// condition code evaluated against the current flag register.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   reset       in   1  synchronous, active-high
//   Instr       in  32  instruction register contents
//   ALUFlags    in   4  {N,Z,C,V} from the datapath ALU (combinational)
//   PCWrite     out  1  PC register enable
//   MemWrite    out  1  data memory write enable
//   RegWrite    out  1  register file write enable
//   IRWrite     out  1  instruction register enable
//   AdrSrc      out  1  memory address select: 0=PC, 1=Result
//   RegSrc      out  2  [0] forces RA1=R15, [1] selects RA2=Instr[15:12]
//   ALUSrcA     out  2  00=PC, 01=A register
//   ALUSrcB     out  2  00=WriteData reg, 01=ExtImm, 10=constant 4
//   ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
//   ImmSrc      out  2  Instr[27:26]
//   ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr
//   InstrCount  out 32  retired-instruction counter (only with MC_PERF_CNT_EN)
//
// Build option: define MC_PERF_CNT_EN to add the InstrCount output and counter.

module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] InstrCount
`endif
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StBranch
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  flags_q;

    // Instruction fields
    logic [1:0]  op;
    logic [3:0]  cmd;
    logic        s_bit;
    logic [3:0]  cond;
    logic        rd_is_pc;

    // Data-processing decode
    logic [1:0]  alu_dec;
    logic        no_write;
    logic        cmd_known;
    logic        cmd_arith;
    logic [1:0]  flag_w;

    logic        cond_ex;
    logic        in_execute;

    assign op       = Instr[27:26];
    assign cmd      = Instr[24:21];
    assign s_bit    = Instr[20];
    assign cond     = Instr[31:28];
    assign rd_is_pc = (Instr[15:12] == 4'hf);

    // ---------------------------------------------------------------------
    // Data-processing command decode
    // ---------------------------------------------------------------------
    always_comb begin
        alu_dec   = 2'b00;
        no_write  = 1'b0;
        cmd_known = 1'b1;
        cmd_arith = 1'b0;
        case (cmd)
            4'b0100: begin
                alu_dec   = 2'b00;
                cmd_arith = 1'b1;
            end
            4'b0010: begin
                alu_dec   = 2'b01;
                cmd_arith = 1'b1;
            end
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            4'b1010: begin
                // CMP: subtract for flags only
                alu_dec   = 2'b01;
                no_write  = 1'b1;
                cmd_arith = 1'b1;
            end
            default: begin
                alu_dec   = 2'b00;
                no_write  = 1'b1;
                cmd_known = 1'b0;
            end
        endcase
    end

    // Unsupported commands never touch the flags, even with S set.
    // C and V only follow arithmetic results.
    assign flag_w = {s_bit & cmd_known, s_bit & cmd_arith};

    // ---------------------------------------------------------------------
    // Condition evaluation against the architectural flags
    // ---------------------------------------------------------------------
    always_comb begin
        logic n, z, c, v;
        n = flags_q[3];
        z = flags_q[2];
        c = flags_q[1];
        v = flags_q[0];
        cond_ex = 1'b1;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            default: cond_ex = 1'b1; // AL, and 1111 treated as AL
        endcase
    end

    // ---------------------------------------------------------------------
    // Flag register
    // ---------------------------------------------------------------------
    assign in_execute = (state_q == StExecuteR) || (state_q == StExecuteI);

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (in_execute && cond_ex) begin
            if (flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // ---------------------------------------------------------------------
    // Main FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (op)
                    2'b00:   state_d = Instr[25] ? StExecuteI : StExecuteR;
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch; // Op11 retires as a NOP
                endcase
            end
            StMemAdr:   state_d = Instr[20] ? StMemRead : StMemWrite;
            StMemRead:  state_d = StMemWb;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            default:    state_d = StFetch; // MemWb, MemWrite, AluWb, Branch
        endcase
    end

    // ---------------------------------------------------------------------
    // Moore outputs; the write enables are masked while reset is held
    // ---------------------------------------------------------------------
    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        ImmSrc     = op;
        RegSrc     = {op == 2'b01, op == 2'b10};

        case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StDecode: begin
                // PC+8 appears on Result for R15 operand reads
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StMemAdr: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex;
                PCWrite   = cond_ex & rd_is_pc;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
            end
            StExecuteR: begin
                ALUSrcA    = 2'b01;
                ALUControl = alu_dec;
            end
            StExecuteI: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            StAluWb: begin
                RegWrite = cond_ex & ~no_write;
                PCWrite  = cond_ex & ~no_write & rd_is_pc;
            end
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
            end
            default: ;
        endcase

        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
        end
    end

`ifdef MC_PERF_CNT_EN
    // ---------------------------------------------------------------------
    // Retired-instruction counter: one tick per return to FETCH
    // ---------------------------------------------------------------------
    logic [31:0] count_q;
    logic        retire;

    assign retire = (state_d == StFetch) &&
                    ((state_q == StMemWb) || (state_q == StMemWrite) ||
                     (state_q == StAluWb) || (state_q == StBranch) ||
                     (state_q == StDecode));

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 32'd0;
        end else if (retire) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign InstrCount = count_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller. A phase-level model computes the
// expected output vector of every cycle; a single compare process checks it.

module tb_mc_controller;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
`ifdef MC_PERF_CNT_EN
    logic [31:0] InstrCount;
    int unsigned m_count;
`endif

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
`ifdef MC_PERF_CNT_EN
        ,
        .InstrCount (InstrCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adrsrc;
        logic [1:0] regsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] ressrc;
        logic [1:0] immsrc;
        logic [1:0] aluctl;
    } outs_t;

    typedef enum {
        PhFetch, PhDecode, PhMemAdr, PhMemRead, PhMemWb, PhMemWrite,
        PhExecR, PhExecI, PhAluWb, PhBranch
    } phase_e;

    localparam logic [16:0] MaskAll = 17'h1ffff;
    localparam logic [16:0] MaskWe  = 17'h1e000; // pcw, memw, regw, irw

    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  m_flags  = 4'b0000;
    outs_t       exp_v;
    logic [16:0] exp_mask;
    bit          exp_valid = 1'b0;
    string       exp_name;
    logic [16:0] dut_v;

    assign dut_v = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                    ALUSrcB, ResultSrc, ImmSrc, ALUControl};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ----------------------------- model ---------------------------------
    // ARM condition: pairs of conditions share a base test, odd codes invert it.
    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return (cc[3:1] == 3'd7) ? 1'b1 : (base ^ cc[0]);
    endfunction

    function automatic int dp_kind(input logic [3:0] cmd);
        // 0 add, 1 sub, 2 and, 3 orr, 4 cmp, 5 unsupported
        if (cmd == 4'b0100) return 0;
        if (cmd == 4'b0010) return 1;
        if (cmd == 4'b0000) return 2;
        if (cmd == 4'b1100) return 3;
        if (cmd == 4'b1010) return 4;
        return 5;
    endfunction

    function automatic outs_t model_out(input phase_e p, input logic [31:0] ins,
                                        input logic [3:0] f);
        outs_t o;
        int    k;
        logic  ce, wr, rdpc;
        o        = '0;
        o.immsrc = ins[27:26];
        o.regsrc = {ins[27:26] == 2'b01, ins[27:26] == 2'b10};
        k        = dp_kind(ins[24:21]);
        ce       = cond_ok(ins[31:28], f);
        wr       = (k <= 3);
        rdpc     = (ins[15:12] == 4'd15);
        case (p)
            PhFetch:    begin o.irw = 1; o.pcw = 1; o.srcb = 2; o.ressrc = 2; end
            PhDecode:   begin o.srcb = 2; o.ressrc = 2; end
            PhMemAdr:   begin o.srca = 1; o.srcb = 1; end
            PhMemRead:  o.adrsrc = 1;
            PhMemWb:    begin o.ressrc = 1; o.regw = ce; o.pcw = ce & rdpc; end
            PhMemWrite: begin o.adrsrc = 1; o.memw = ce; end
            PhExecR, PhExecI: begin
                o.srca   = 1;
                o.srcb   = (p == PhExecI) ? 2'd1 : 2'd0;
                o.aluctl = (k == 4) ? 2'd1 : (k == 5) ? 2'd0 : 2'(k);
            end
            PhAluWb:    begin o.regw = ce & wr; o.pcw = ce & wr & rdpc; end
            PhBranch:   begin o.srcb = 1; o.ressrc = 2; o.pcw = ce; end
            default: ;
        endcase
        return o;
    endfunction

    // ----------------------------- compare -------------------------------
    always @(negedge clk) begin
        if (exp_valid) begin
            n_checks++;
            if ((dut_v & exp_mask) !== (exp_v & exp_mask)) begin
                n_errors++;
                $display("FAIL outputs %s @%0t: got %05h, expected %05h (mask %05h)",
                         exp_name, $time, dut_v & exp_mask, exp_v & exp_mask, exp_mask);
            end
            if (exp_mask == MaskAll) begin
                n_checks++;
                if (dut.flags_q !== m_flags) begin
                    n_errors++;
                    $display("FAIL flags %s @%0t: got %h, expected %h",
                             exp_name, $time, dut.flags_q, m_flags);
                end
`ifdef MC_PERF_CNT_EN
                n_checks++;
                if (InstrCount !== m_count) begin
                    n_errors++;
                    $display("FAIL instrcount %s @%0t: got %0d, expected %0d",
                             exp_name, $time, InstrCount, m_count);
                end
`endif
            end
        end
    end

    // ----------------------------- stimulus ------------------------------
    task automatic do_reset(input int cycles);
        reset     = 1'b1;
        exp_v     = '0;
        exp_mask  = MaskWe;
        exp_name  = "reset";
        exp_valid = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        reset   = 1'b0;
        m_flags = 4'b0000;
`ifdef MC_PERF_CNT_EN
        m_count = 0;
`endif
    endtask

    task automatic run_instr(input string name, input logic [31:0] ins,
                             input logic [3:0] aluf, input int reset_at,
                             output int ncyc);
        phase_e path[$];
        int     k;
        path = '{PhFetch, PhDecode};
        case (ins[27:26])
            2'b00: begin
                path.push_back(ins[25] ? PhExecI : PhExecR);
                path.push_back(PhAluWb);
            end
            2'b01: begin
                path.push_back(PhMemAdr);
                if (ins[20]) begin
                    path.push_back(PhMemRead);
                    path.push_back(PhMemWb);
                end else begin
                    path.push_back(PhMemWrite);
                end
            end
            2'b10: path.push_back(PhBranch);
            default: ;
        endcase
        k = dp_kind(ins[24:21]);
        for (int i = 0; i < path.size(); i++) begin
            if (i == reset_at) begin
                do_reset(2);
                ncyc = i;
                return;
            end
            Instr     = ins;
            ALUFlags  = aluf;
            exp_v     = model_out(path[i], ins, m_flags);
            exp_mask  = MaskAll;
            exp_name  = $sformatf("%s/%s", name, path[i].name());
            exp_valid = 1'b1;
            @(posedge clk);
            #1;
            if ((path[i] == PhExecR || path[i] == PhExecI) && ins[20] && k <= 4 &&
                cond_ok(ins[31:28], m_flags)) begin
                m_flags[3:2] = aluf[3:2];
                if (k == 0 || k == 1 || k == 4) m_flags[1:0] = aluf[1:0];
            end
`ifdef MC_PERF_CNT_EN
            if (i == path.size() - 1) m_count++;
`endif
        end
        ncyc = path.size();
    endtask

    initial begin
        int n;
        logic [3:0] cc;
        reset    = 1'b1;
        Instr    = 32'h0;
        ALUFlags = 4'h0;
        do_reset(2);
        check("reset_flags", {28'h0, dut.flags_q}, 32'h0);

        run_instr("add", 32'hE0802001, 4'b0000, -1, n);
        check("add_cycles", n, 4);
        run_instr("subs", 32'hE0513001, 4'b0100, -1, n);
        check("subs_model_flags", {28'h0, m_flags}, 32'h4);
        check("subs_dut_flags", {28'h0, dut.flags_q}, 32'h4);
        run_instr("beq", 32'h0A000002, 4'b0000, -1, n);
        check("b_cycles", n, 3);
        run_instr("bne", 32'h1A000002, 4'b0000, -1, n);
        run_instr("ldr", 32'hE5904008, 4'b0000, -1, n);
        check("ldr_cycles", n, 5);
        run_instr("str", 32'hE5804008, 4'b0000, -1, n);
        check("str_cycles", n, 4);
        run_instr("addne", 32'h10802001, 4'b1111, -1, n);
        check("addne_cycles", n, 4);
        for (int c = 0; c < 16; c++) begin
            cc = 4'(c);
            run_instr("bcc_z", {cc, 28'hA000002}, 4'b0000, -1, n);
        end
        run_instr("subs_ncv", 32'hE0513001, 4'b1011, -1, n);
        for (int c = 0; c < 16; c++) begin
            cc = 4'(c);
            run_instr("bcc_ncv", {cc, 28'hA000002}, 4'b0000, -1, n);
        end
        run_instr("orr_imm", 32'hE3811005, 4'b0000, -1, n);
        run_instr("and", 32'hE0012003, 4'b0000, -1, n);
        run_instr("movs_unsup", 32'hE1B00000, 4'b0101, -1, n);
        check("unsup_keeps_flags", {28'h0, m_flags}, 32'hB);
        run_instr("add_pc", 32'hE080F001, 4'b0000, -1, n);
        run_instr("ldr_pc", 32'hE590F008, 4'b0000, -1, n);
        run_instr("nop_op11", 32'hEC000000, 4'b0000, -1, n);
        check("op11_cycles", n, 2);
        run_instr("cmp", 32'hE1510001, 4'b0110, -1, n);
        check("cmp_model_flags", {28'h0, m_flags}, 32'h6);
        check("cmp_dut_flags", {28'h0, dut.flags_q}, 32'h6);
        run_instr("ldr_rst", 32'hE5904008, 4'b0000, 3, n);
        check("reset_mid_flags", {28'h0, dut.flags_q}, 32'h0);
`ifdef MC_PERF_CNT_EN
        check("reset_mid_count", InstrCount, 32'h0);
`endif
        run_instr("add_after_rst", 32'hE0802001, 4'b0000, -1, n);
        run_instr("beq_after_rst", 32'h0A000002, 4'b0000, -1, n);

        exp_valid = 1'b0;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit that sits directly upstream of the datapath and drives every datapath select and enable.
- Decodes the latched instruction (Instr) and sequences a Moore main FSM.
- Holds the NZCV flag register and evaluates the condition code, gating architectural writes.
- Supported instructions: ADD, SUB, AND, ORR, CMP (register or imm8), LDR/STR (imm12, add offset), B.

Parameters:
- None.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- Instr  in  32  instruction register contents from datapath
- ALUFlags  in  4  {N,Z,C,V} from datapath ALU, combinational
- PCWrite  out  1  PC register enable
- MemWrite  out  1  data memory write enable
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=Result
- RegSrc  out  2  [0]=1 forces RA1=R15; [1]=1 selects RA2=Instr[15:12]
- ALUSrcA  out  2  00=PC, 01=A register
- ALUSrcB  out  2  00=WriteData reg, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  out  2  equals Instr[27:26]
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr

Behaviour:
- Decode. Op = Instr[27:26]. DP cmd = Instr[24:21]:
  - 0100 ADD→00
  - 0010 SUB→01
  - 0000 AND→10
  - 1100 ORR→11
  - 1010 CMP→01 with NoWrite
  - any other cmd: ALUControl 00, NoWrite, no flag write
- FlagW. FlagW[1] = S (Instr[20]). FlagW[0] = S & cmd is add/sub/cmp.
- RegSrc. RegSrc[0] = (Op==10). RegSrc[1] = (Op==01).
- Condition. CondEx is combinational from Instr[31:28] and the Flags register:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL 1; 1111 is treated as AL
- Flags register:
  - Written only in EXECUTER/EXECUTEI, and only when CondEx=1.
  - Flags[3:2] ← ALUFlags[3:2] when FlagW[1].
  - Flags[1:0] ← ALUFlags[1:0] when FlagW[0].
- FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op00 with Instr[25]=0→EXECUTER; Op00 with Instr[25]=1→EXECUTEI; Op01→MEMADR; Op10→BRANCH; Op11→FETCH (NOP).
  - MEMADR: Instr[20]=1→MEMREAD, else MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER/EXECUTEI→ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH→FETCH.
- Outputs are Moore; any signal not listed is 0.
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - DECODE: ALUSrcA=00, ALUSrcB=10, ALUControl=00, ResultSrc=10 (PC+8 for R15 reads).
  - MEMADR: ALUSrcA=01, ALUSrcB=01, ALUControl=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=CondEx, PCWrite=CondEx&(Rd==15).
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=CondEx.
  - EXECUTER: ALUSrcA=01, ALUSrcB=00, ALUControl=decoded.
  - EXECUTEI: same as EXECUTER but ALUSrcB=01.
  - ALUWB: ResultSrc=00, RegWrite=CondEx&!NoWrite, PCWrite=CondEx&!NoWrite&(Rd==15).
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=CondEx.
- Rd = Instr[15:12].
- Cycle counts:
  - A failed condition still walks the full state path (same cycle count) with writes suppressed.
  - Latency: DP 4 cycles, LDR 5, STR 4, B 3, Op11 2.
- Reset:
  - On the clock edge with reset=1: state←FETCH, Flags←0000.
  - While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced 0, including mid-instruction.
  - On the first cycle after deassertion the FSM is in FETCH with normal outputs.

Optional Feature:
- MC_PERF_CNT_EN defined:
  - Adds output InstrCount (32 bits), reset to 0.
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or DECODE (Op11).
  - Condition-failed instructions are counted.
  - Wraps 0xFFFFFFFF→0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then Instr=0xE0802001 (ADD R2,R0,R1) → states FETCH,DECODE,EXECUTER,ALUWB,FETCH; ALUControl=00 in EXECUTER; RegWrite=1 only in ALUWB; IRWrite=PCWrite=1 only in FETCH.
- Instr=0xE0513001 (SUBS) with ALUFlags=0100 in EXECUTER → Flags=0100.
  - Then 0x0A000002 (BEQ) → BRANCH with PCWrite=1, ImmSrc=10, RegSrc[0]=1.
  - Then 0x1A000002 (BNE) → BRANCH with PCWrite=0.
- Instr=0xE5904008 (LDR) → MEMADR,MEMREAD (AdrSrc=1),MEMWB (ResultSrc=01, RegWrite=1).
  - Then 0xE5804008 (STR) → MEMWRITE with MemWrite=1, RegSrc=10.
- Flags Z=1, Instr=0x10802001 (ADDNE) → 4 cycles, RegWrite=0 in ALUWB.
- Instr=0xE1510001 (CMP) with ALUFlags=0110 → ALUControl=01, Flags=0110, RegWrite=0 in ALUWB.
- reset pulsed during MEMREAD → all write enables 0 during reset; next state FETCH; Flags=0000; InstrCount=0 when MC_PERF_CNT_EN is defined.
